// File: rtl/serial_frame_rx.sv
// serial_frame_rx: receive-path front end fed by the registered serial bit stream.
// It hunts for SYNC_PAT, collects a DATA_W-bit word (MSB first), optionally checks
// an even-parity bit, and presents the word on a 1-deep valid/ready buffer.
// Optional feature macro: PARITY_CHK_EN. When it is defined, a PAR state takes the
// parity bit after the data word. When it is not defined, the word is loaded on the
// edge that takes its last data bit, and parity_err is tied low.
module serial_frame_rx #(
    parameter int unsigned       SYNC_W   = 8,
    parameter logic [SYNC_W-1:0] SYNC_PAT = 8'hA5,
    parameter int unsigned       DATA_W   = 8,
    parameter int unsigned       CNT_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bit_in,
    input  logic              bit_en,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    input  logic              data_ready,
    output logic              parity_err,
    output logic              overrun,
    output logic              busy,
    output logic [CNT_W-1:0]  frame_cnt
);

    localparam int unsigned BIT_CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        ST_HUNT = 2'd0,
        ST_DATA = 2'd1,
        ST_PAR  = 2'd2
    } state_t;

    state_t                state_q,      state_d;
    logic [SYNC_W-1:0]     sync_sr_q,    sync_sr_d;
    logic [DATA_W-1:0]     data_sr_q,    data_sr_d;
    logic [BIT_CNT_W-1:0]  bit_cnt_q,    bit_cnt_d;
    logic [DATA_W-1:0]     data_out_q,   data_out_d;
    logic                  data_valid_q, data_valid_d;
    logic                  parity_err_q, parity_err_d;
    logic                  overrun_q,    overrun_d;
    logic                  busy_q,       busy_d;
    logic [CNT_W-1:0]      frame_cnt_q,  frame_cnt_d;

    // Post-shift views of the two shift registers for the current bit.
    logic [SYNC_W-1:0] sync_shift;
    logic [DATA_W-1:0] data_shift;
    // Word and parity verdict presented to the buffer when a frame completes.
    logic [DATA_W-1:0] frame_word;
    logic              parity_mis;

    assign sync_shift = {sync_sr_q[SYNC_W-2:0], bit_in};
    assign data_shift = {data_sr_q[DATA_W-2:0], bit_in};

`ifdef PARITY_CHK_EN
    // The data word is complete in data_sr by the time the parity bit arrives.
    assign frame_word = data_sr_q;
    assign parity_mis = bit_in ^ (^data_sr_q);
`else
    // No parity bit: the word completes with the bit being sampled right now.
    logic unused_data_msb;
    assign frame_word      = data_shift;
    assign parity_mis      = 1'b0;
    assign unused_data_msb = data_sr_q[DATA_W-1];
`endif

    // Next-state logic: frame sequencing, buffer load/drain and sticky flags.
    always_comb begin
        logic frame_done;
        logic load_ok;

        // NOTE: every variable gets a default before any branch so that no path
        // leaves it unassigned; a missing default here would infer a latch.
        state_d      = state_q;
        sync_sr_d    = sync_sr_q;
        data_sr_d    = data_sr_q;
        bit_cnt_d    = bit_cnt_q;
        data_out_d   = data_out_q;
        data_valid_d = data_valid_q;
        parity_err_d = parity_err_q;
        overrun_d    = overrun_q;
        frame_cnt_d  = frame_cnt_q;
        frame_done   = 1'b0;

        // The buffer can take a new word if it is empty or is drained this edge.
        load_ok = !data_valid_q || data_ready;

        if (data_valid_q && data_ready) begin
            data_valid_d = 1'b0;
        end

        if (bit_en) begin
            case (state_q)
                ST_HUNT: begin
                    // Sliding window: no restart on mismatch, overlaps are found.
                    sync_sr_d = sync_shift;
                    if (sync_shift == SYNC_PAT) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = '0;
                    end
                end
                ST_DATA: begin
                    data_sr_d = data_shift;
                    bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    if (bit_cnt_q == LAST_BIT) begin
`ifdef PARITY_CHK_EN
                        state_d = ST_PAR;
`else
                        frame_done = 1'b1;
`endif
                    end
                end
`ifdef PARITY_CHK_EN
                ST_PAR: begin
                    frame_done = 1'b1;
                end
`endif
                default: begin
                    state_d = ST_HUNT;
                end
            endcase
        end

        if (frame_done) begin
            // Clearing the sync window keeps old bits from faking a new sync.
            state_d   = ST_HUNT;
            sync_sr_d = '0;
            if (load_ok) begin
                data_out_d   = frame_word;
                data_valid_d = 1'b1;
                parity_err_d = parity_mis;
                frame_cnt_d  = frame_cnt_q + CNT_W'(1);
            end else begin
                overrun_d = 1'b1;
            end
        end

        busy_d = (state_d == ST_DATA) || (state_d == ST_PAR);
    end

    // State register with synchronous, active-high reset taking priority.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments here so every flop samples the values of
        // the previous cycle, independent of statement order.
        if (rst) begin
            state_q      <= ST_HUNT;
            sync_sr_q    <= '0;
            data_sr_q    <= '0;
            bit_cnt_q    <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
            busy_q       <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            sync_sr_q    <= sync_sr_d;
            data_sr_q    <= data_sr_d;
            bit_cnt_q    <= bit_cnt_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            parity_err_q <= parity_err_d;
            overrun_q    <= overrun_d;
            busy_q       <= busy_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign parity_err = parity_err_q;
    assign overrun    = overrun_q;
    assign busy       = busy_q;
    assign frame_cnt  = frame_cnt_q;

endmodule

// File: doc/serial_frame_rx.md
Name: serial_frame_rx

Overview:
- Downstream consumer of the registered serial bit stream produced by the team's D flip-flop stage (its q output drives bit_in).
- Hunts for a sync word, then collects a fixed-width data word and an even-parity bit.
- Presents the word on a 1-deep valid/ready output buffer.
- Serves as the front end of the serial receive path.

Parameters:
- SYNC_W, 8, sync word width in bits.
- SYNC_PAT, 8'hA5, sync word, MSB received first; must be nonzero.
- DATA_W, 8, data word width in bits, MSB received first.
- CNT_W, 8, width of the accepted-frame counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- bit_in  input  1  serial data bit (registered q of the upstream flip-flop).
- bit_en  input  1  qualifies bit_in; bit sampled only when high.
- data_out  output  DATA_W  received word (output buffer).
- data_valid  output  1  buffer holds an unconsumed word.
- data_ready  input  1  consumer accepts data_out when data_valid && data_ready.
- parity_err  output  1  parity mismatch flag for the word in the buffer.
- overrun  output  1  sticky: a completed frame was dropped because the buffer was full.
- busy  output  1  high in DATA or PAR state.
- frame_cnt  output  CNT_W  count of frames loaded into the buffer; wraps.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset: rst sampled high at a rising edge of clk forces state=HUNT and clears sync shift reg, data shift reg, bit counter, data_out, data_valid, parity_err, overrun and frame_cnt to 0. Reset has priority over every event, including mid-frame; a partial frame is discarded.
- bit_en low: no state, shift or counter change. The output handshake still operates.
- HUNT:
  - On bit_en, sync_sr <= {sync_sr[SYNC_W-2:0], bit_in}.
  - If the post-shift value == SYNC_PAT: go to DATA, bit_cnt <= 0.
  - Overlapping detection: matching uses the sliding window, no restart on mismatch.
- DATA:
  - On bit_en, data_sr <= {data_sr[DATA_W-2:0], bit_in} and bit_cnt increments.
  - When the DATA_W-th bit is taken (bit_cnt == DATA_W-1), go to PAR.
- PAR:
  - On bit_en, the received bit is compared with the XOR-reduce of data_sr (even parity).
  - Load condition: the buffer is free (!data_valid) or drains in the same cycle (data_valid && data_ready).
  - If the load condition holds: data_out <= data_sr, data_valid <= 1, parity_err <= mismatch, frame_cnt <= frame_cnt+1 (wraps at 2^CNT_W).
  - Otherwise: frame dropped, overrun <= 1 (sticky until rst), buffer unchanged.
  - In both cases: state <= HUNT, sync_sr <= 0, so no stale bits create a false sync.
- Latency: data_valid rises on the same edge that samples the parity bit.
- Output handshake:
  - data_valid && data_ready at an edge clears data_valid, unless the same edge loads a new frame, in which case data_valid stays 1 with new contents.
  - data_out and parity_err hold while data_valid is high and data_ready is low.
- Parity errors are still delivered and counted; the consumer decides.
- busy = (state==DATA || state==PAR).

Optional Feature:
- PARITY_CHK_EN.
- Defined: behaviour as above, with the PAR state and parity bit present.
- Undefined:
  - No PAR state; the frame is loaded (same load/overrun rules) on the edge that samples the DATA_W-th data bit, then the block returns to HUNT.
  - parity_err tied 0.
  - Frame length is SYNC_W+DATA_W bits.

Test Plan (defaults, PARITY_CHK_EN defined, bits sent MSB-first with bit_en=1 unless stated):
- Reset: rst=1 for 2 edges mid-stream -> data_out=0, data_valid=0, parity_err=0, overrun=0, busy=0, frame_cnt=0.
- Good frame: send A5, 3C, parity 0, data_ready=0 -> data_valid=1 on the parity-bit edge; data_out=8'h3C, parity_err=0, frame_cnt=1. Then data_ready=1 for 1 edge -> data_valid=0.
- Bad parity and near-miss sync:
  - Send A4 -> no sync, busy stays 0.
  - Then send A5, 3C, parity 1 -> data_out=8'h3C, parity_err=1, frame_cnt=1.
- Overrun: data_ready=0; send frames A5/11/p0 then A5/22/p0 -> data_out stays 8'h11, overrun=1, frame_cnt=1. Then data_ready=1 -> data_valid=0, overrun stays 1.
- Gaps and simultaneous load/drain:
  - Send A5, 3C, parity 0 with bit_en=0 on alternate cycles -> same result as the good-frame case.
  - Then hold data_ready=1 while the next frame A5/81/p0 loads on the edge that drains -> data_valid stays 1, data_out=8'h81, frame_cnt=2.
- Reset mid-operation: send A5 then 4 data bits, assert rst for 1 edge, then send A5, C3, parity 0 -> only 8'hC3 delivered, frame_cnt=1.
